// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// Shares the single framebuffer write port between processor stores and a
// hardware fill engine. Processor stores are never stalled: they either
// bypass straight to the port or wait in a small FIFO. The fill engine
// takes idle cycles, and a starvation counter forces a fill write after
// STARVE_LIMIT consecutive CPU grants while a fill is pending.
module fb_write_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FB_SIZE      = 307200,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cpu_wren,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [DATA_W-1:0]               cpu_data,
  input  logic                            fill_start,
  input  logic [ADDR_W-1:0]               fill_base,
  input  logic [ADDR_W-1:0]               fill_len,
  input  logic [DATA_W-1:0]               fill_color,
  output logic                            fill_busy,
  output logic                            fill_done,
  output logic                            fb_wren,
  output logic [ADDR_W-1:0]               fb_addr,
  output logic [DATA_W-1:0]               fb_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_W:0]     FB_SIZE_X = (ADDR_W + 1)'(FB_SIZE);
  localparam logic [ADDR_W-1:0]   FB_SIZE_A = ADDR_W'(FB_SIZE);
  localparam logic [ADDR_W-1:0]   FB_LAST   = ADDR_W'(FB_SIZE - 1);
  localparam logic [CNT_W-1:0]    FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  fill_state_t state;
  fill_state_t state_next;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [ADDR_W-1:0]   cursor;
  logic [ADDR_W-1:0]   remaining;
  logic [DATA_W-1:0]   color;
  logic [STARVE_W-1:0] starve_cnt;

  logic              fifo_empty;
  logic              fifo_full;
  logic              cpu_pending;
  logic              fill_pending;
  logic              grant_fill;
  logic              grant_cpu;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              do_pop;
  logic              want_push;
  logic              do_push;
  logic              drop;
  logic [ADDR_W-1:0] base_norm;
  logic [ADDR_W-1:0] cursor_inc;

  // Arbitration: the starvation guard beats the CPU, otherwise the CPU wins.
  always_comb begin
    fifo_empty   = (fifo_count == '0);
    fifo_full    = (fifo_count == FIFO_FULL);
    cpu_pending  = !fifo_empty || cpu_wren;
    fill_pending = (state == FILL);
    grant_fill   = fill_pending && ((starve_cnt == STARVE_MAX) || !cpu_pending);
    grant_cpu    = cpu_pending && !grant_fill;
  end

  // CPU head selection and FIFO push/pop/drop decisions; an empty FIFO lets the incoming store bypass.
  always_comb begin
    head_addr = cpu_addr;
    head_data = cpu_data;
    if (!fifo_empty) begin
      head_addr = fifo_addr[rd_ptr];
      head_data = fifo_data[rd_ptr];
    end
    do_pop    = grant_cpu && !fifo_empty;
    want_push = cpu_wren && !(grant_cpu && fifo_empty);
    do_push   = want_push && (!fifo_full || do_pop);
    drop      = want_push && fifo_full && !do_pop;
  end

  // Fill address helpers: fold an out-of-range base once, and wrap the cursor at the last pixel.
  always_comb begin
    base_norm = fill_base;
    if ({1'b0, fill_base} >= FB_SIZE_X) begin
      base_norm = fill_base - FB_SIZE_A;
    end
    cursor_inc = cursor + ADDR_W'(1);
    if (cursor == FB_LAST) begin
      cursor_inc = '0;
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Fill FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_next = (fill_len != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (grant_fill && (remaining == ADDR_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fill FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fill job registers: latched on an accepted start, advanced on every fill grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cursor    <= '0;
      remaining <= '0;
      color     <= '0;
    end else if ((state == IDLE) && fill_start) begin
      cursor    <= base_norm;
      remaining <= fill_len;
      color     <= fill_color;
    end else if (grant_fill) begin
      cursor    <= cursor_inc;
      remaining <= remaining - ADDR_W'(1);
    end
  end

  // Starvation counter: counts CPU grants that pass over a pending fill.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!fill_pending || grant_fill) begin
      starve_cnt <= '0;
    end else if (grant_cpu) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Registered outputs; fill_done trails the DONE state by a cycle so it lands after the final write shows.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fb_wren   <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_busy <= (state_next == FILL);
      fill_done <= (state == DONE);
      if (grant_fill) begin
        fb_wren <= 1'b1;
        fb_addr <= cursor;
        fb_data <= color;
      end else if (grant_cpu) begin
        fb_wren <= 1'b1;
        fb_addr <= head_addr;
        fb_data <= head_data;
      end else begin
        fb_wren <= 1'b0;
      end
    end
  end

endmodule
